// File: rtl/rv32_regs_ctrl_pkg.sv
// Shared types and widths for the rv32 register-file sequencer/arbiter.
package rv32_regs_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RUN     = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/rv32_regs_ctrl.sv
// Register-file owner: zero-fills x1..x31, then arbitrates writeback vs debug writes (0-cycle accept, starvation stall)
// and serves debug reads over the rs1 path in 3 cycles, freezing the pipeline and restoring its read addresses.
module rv32_regs_ctrl
    import rv32_regs_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall_in,
    input  logic [REG_ADDR_W-1:0] rs1_in,
    input  logic [REG_ADDR_W-1:0] rs2_in,
    input  logic [REG_ADDR_W-1:0] wb_rd_in,
    input  logic                  wb_rd_write_in,
    input  logic [XLEN-1:0]       wb_rd_value_in,
    input  logic                  wb_flush_in,
    output logic                  regs_stall_out,
    output logic [REG_ADDR_W-1:0] regs_rs1_out,
    output logic [REG_ADDR_W-1:0] regs_rs2_out,
    output logic [REG_ADDR_W-1:0] regs_rd_out,
    output logic                  regs_rd_write_out,
    output logic [XLEN-1:0]       regs_rd_value_out,
    input  logic [XLEN-1:0]       regs_rs1_value_in,
    output logic                  pipe_stall_out,
    input  logic                  dbg_valid_in,
    output logic                  dbg_ready_out,
    input  logic                  dbg_write_in,
    input  logic [REG_ADDR_W-1:0] dbg_addr_in,
    input  logic [XLEN-1:0]       dbg_wdata_in,
    output logic                  dbg_rvalid_out,
    output logic [XLEN-1:0]       dbg_rdata_out
);

    localparam state_t     RST_STATE  = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [REG_ADDR_W-1:0] r_clr_idx;
    logic [REG_ADDR_W-1:0] r_sh_rs1;
    logic [REG_ADDR_W-1:0] r_sh_rs2;
    logic [REG_ADDR_W-1:0] r_dbg_addr;
    logic [7:0]            r_starve_cnt;
    logic                  r_starve_stall;
    logic [XLEN-1:0]       r_rdata;

    logic                  w_run;
    logic                  w_pipe_wr;
    logic                  w_fwd;
    logic                  w_dbg_wr_req;
    logic                  w_dbg_wr_acc;
    logic                  w_dbg_rd_acc;
    logic                  w_clr_wr;
    logic [XLEN-1:0]       w_rd_rdata;

    assign w_run        = (r_state == RUN);
    assign w_pipe_wr    = wb_rd_write_in && !wb_flush_in && (wb_rd_in != '0);
    // The starvation stall cycle blocks writeback so the debug write wins it.
    assign w_fwd        = w_run && w_pipe_wr && !r_starve_stall;
    assign w_dbg_wr_req = w_run && dbg_valid_in && dbg_write_in;
    assign w_dbg_wr_acc = w_dbg_wr_req && !w_fwd;
    assign w_dbg_rd_acc = w_run && dbg_valid_in && !dbg_write_in;
    // Keep the write port quiet while reset is held even though the state already reads CLEAR.
    assign w_clr_wr     = (r_state == CLEAR) && reset_n;
    assign w_rd_rdata   = (r_dbg_addr == '0) ? '0 : regs_rs1_value_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        pipe_stall_out = 1'b1;
        regs_stall_out = 1'b1;
        regs_rs1_out   = r_sh_rs1;
        regs_rs2_out   = r_sh_rs2;
        dbg_ready_out  = 1'b0;
        dbg_rvalid_out = 1'b0;
        dbg_rdata_out  = r_rdata;
        case (r_state)
            CLEAR: begin
                if (r_clr_idx == 5'd31) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                pipe_stall_out = r_starve_stall;
                regs_stall_out = stall_in;
                regs_rs1_out   = rs1_in;
                regs_rs2_out   = rs2_in;
                dbg_ready_out  = w_dbg_wr_acc || w_dbg_rd_acc;
                if (w_dbg_rd_acc) begin
                    w_state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                regs_stall_out = 1'b0;
                regs_rs1_out   = r_dbg_addr;
                w_state_nxt    = RD_DATA;
            end
            RD_DATA: begin
                regs_stall_out = 1'b0;
                dbg_rvalid_out = 1'b1;
                dbg_rdata_out  = w_rd_rdata;
                w_state_nxt    = RUN;
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase
    end

    always_comb begin
        regs_rd_write_out = 1'b0;
        regs_rd_out       = '0;
        regs_rd_value_out = '0;
        if (w_clr_wr) begin
            regs_rd_write_out = 1'b1;
            regs_rd_out       = r_clr_idx;
        end else if (w_fwd) begin
            regs_rd_write_out = 1'b1;
            regs_rd_out       = wb_rd_in;
            regs_rd_value_out = wb_rd_value_in;
        end else if (w_dbg_wr_acc && (dbg_addr_in != '0)) begin
            regs_rd_write_out = 1'b1;
            regs_rd_out       = dbg_addr_in;
            regs_rd_value_out = dbg_wdata_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_idx  <= 5'd1;
            r_sh_rs1   <= '0;
            r_sh_rs2   <= '0;
            r_dbg_addr <= '0;
            r_rdata    <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_clr_idx <= r_clr_idx + 5'd1;
            end
            if (w_run && !stall_in) begin
                r_sh_rs1 <= rs1_in;
                r_sh_rs2 <= rs2_in;
            end
            if (w_dbg_rd_acc) begin
                r_dbg_addr <= dbg_addr_in;
            end
            if (r_state == RD_DATA) begin
                r_rdata <= w_rd_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt   <= '0;
            r_starve_stall <= 1'b0;
        end else if (w_run) begin
            if (r_starve_stall) begin
                r_starve_cnt   <= '0;
                r_starve_stall <= 1'b0;
            end else if (w_dbg_wr_acc) begin
                r_starve_cnt <= '0;
            end else if (w_dbg_wr_req) begin
                if (r_starve_cnt != 8'hFF) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end
                if ((r_starve_cnt + 8'd1) >= STARVE_LIM) begin
                    r_starve_stall <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_regs_ctrl.sv
// Directed bench for rv32_regs_ctrl with a behavioural register file (write port + stall-gated address latches).
module tb_rv32_regs_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_in;
    logic [4:0]  rs1_in, rs2_in, wb_rd_in;
    logic        wb_rd_write_in, wb_flush_in;
    logic [31:0] wb_rd_value_in;
    logic        regs_stall_out;
    logic [4:0]  regs_rs1_out, regs_rs2_out, regs_rd_out;
    logic        regs_rd_write_out;
    logic [31:0] regs_rd_value_out, regs_rs1_value_in;
    logic        pipe_stall_out;
    logic        dbg_valid_in, dbg_ready_out, dbg_write_in;
    logic [4:0]  dbg_addr_in;
    logic [31:0] dbg_wdata_in;
    logic        dbg_rvalid_out;
    logic [31:0] dbg_rdata_out;

    always #5 clk = ~clk;

    rv32_regs_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall_in          (stall_in),
        .rs1_in            (rs1_in),
        .rs2_in            (rs2_in),
        .wb_rd_in          (wb_rd_in),
        .wb_rd_write_in    (wb_rd_write_in),
        .wb_rd_value_in    (wb_rd_value_in),
        .wb_flush_in       (wb_flush_in),
        .regs_stall_out    (regs_stall_out),
        .regs_rs1_out      (regs_rs1_out),
        .regs_rs2_out      (regs_rs2_out),
        .regs_rd_out       (regs_rd_out),
        .regs_rd_write_out (regs_rd_write_out),
        .regs_rd_value_out (regs_rd_value_out),
        .regs_rs1_value_in (regs_rs1_value_in),
        .pipe_stall_out    (pipe_stall_out),
        .dbg_valid_in      (dbg_valid_in),
        .dbg_ready_out     (dbg_ready_out),
        .dbg_write_in      (dbg_write_in),
        .dbg_addr_in       (dbg_addr_in),
        .dbg_wdata_in      (dbg_wdata_in),
        .dbg_rvalid_out    (dbg_rvalid_out),
        .dbg_rdata_out     (dbg_rdata_out)
    );

    // Register file model; poison fills it with non-zero junk so the clear is observable.
    logic [31:0] rf [32];
    logic [4:0]  lat1, lat2;
    logic        poison;
    logic [31:0] rf_rs2_val;

    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A50000 | i;
            lat1 <= 5'd0;
            lat2 <= 5'd0;
        end else begin
            if (regs_rd_write_out && regs_rd_out != 5'd0) rf[regs_rd_out] <= regs_rd_value_out;
            if (!regs_stall_out) begin
                lat1 <= regs_rs1_out;
                lat2 <= regs_rs2_out;
            end
        end
    end
    assign regs_rs1_value_in = (lat1 == 5'd0) ? 32'd0 : rf[lat1];
    assign rf_rs2_val        = (lat2 == 5'd0) ? 32'd0 : rf[lat2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall_in = 1'b0; rs1_in = 5'd0; rs2_in = 5'd0;
        wb_rd_in = 5'd0; wb_rd_write_in = 1'b0; wb_rd_value_in = 32'd0; wb_flush_in = 1'b0;
        dbg_valid_in = 1'b0; dbg_write_in = 1'b0; dbg_addr_in = 5'd0; dbg_wdata_in = 32'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pipe_stall"}, 32'(pipe_stall_out), 32'd1);
        check({tag, " rd_write"},   32'(regs_rd_write_out), 32'd0);
        check({tag, " rd"},         32'(regs_rd_out), 32'd0);
        check({tag, " rd_value"},   regs_rd_value_out, 32'd0);
        check({tag, " dbg_ready"},  32'(dbg_ready_out), 32'd0);
        check({tag, " rvalid"},     32'(dbg_rvalid_out), 32'd0);
        check({tag, " rdata"},      dbg_rdata_out, 32'd0);
        check({tag, " regs_stall"}, 32'(regs_stall_out), 32'd1);
        check({tag, " regs_rs1"},   32'(regs_rs1_out), 32'd0);
        check({tag, " regs_rs2"},   32'(regs_rs2_out), 32'd0);
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic pipe_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        idle_inputs();
        rs1_in = addr;
        @(negedge clk); #1;
        check(name, regs_rs1_value_in, exp);
        @(negedge clk);
    endtask

    task automatic dbg_wr(input logic [4:0] addr, input logic [31:0] data, input string name);
        idle_inputs();
        dbg_valid_in = 1'b1; dbg_write_in = 1'b1; dbg_addr_in = addr; dbg_wdata_in = data;
        #1 check(name, 32'(dbg_ready_out), 32'd1);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic dbg_rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        idle_inputs();
        dbg_valid_in = 1'b1; dbg_addr_in = addr;
        #1 check({name, " ready"}, 32'(dbg_ready_out), 32'd1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk); #1;
        check({name, " rvalid"}, 32'(dbg_rvalid_out), 32'd1);
        check({name, " rdata"}, dbg_rdata_out, exp);
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic [4:0]  rs1, rs2, wb_rd;
        logic        wb_wr;
        logic [31:0] wb_val;
        logic        wb_flush, dv, dw;
        logic [4:0]  da;
        logic [31:0] dd;
        logic        e_rstall;
        logic [4:0]  e_rs1, e_rs2;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [10];
    int   k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd2, 1'b0, 5'd0,  32'h0,        1'b0};
        vecs[1] = '{1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd4, 1'b0, 5'd0,  32'h0,        1'b0};
        vecs[2] = '{1'b0, 5'd1, 5'd2, 5'd6, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd2, 1'b1, 5'd6,  32'h11,       1'b0};
        vecs[3] = '{1'b0, 5'd1, 5'd2, 5'd6, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd2, 1'b0, 5'd0,  32'h0,        1'b0};
        vecs[4] = '{1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd2, 1'b0, 5'd0,  32'h0,        1'b0};
        vecs[5] = '{1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd1, 5'd2, 1'b1, 5'd7,  32'hDEADBEEF, 1'b1};
        vecs[6] = '{1'b0, 5'd1, 5'd2, 5'd2, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 5'd8, 32'hCAFE,     1'b0, 5'd1, 5'd2, 1'b1, 5'd2,  32'h22,       1'b0};
        vecs[7] = '{1'b0, 5'd1, 5'd2, 5'd2, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 5'd8, 32'hCAFE,     1'b0, 5'd1, 5'd2, 1'b1, 5'd8,  32'hCAFE,     1'b1};
        vecs[8] = '{1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd1, 5'd2, 1'b0, 5'd0,  32'h0,        1'b1};
        vecs[9] = '{1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 32'h5,  1'b0, 1'b1, 1'b1, 5'd11, 32'h33,      1'b0, 5'd1, 5'd2, 1'b1, 5'd11, 32'h33,       1'b1};

        idle_inputs();
        reset_n = 1'b0;
        poison  = 1'b1;
        @(negedge clk);
        poison = 1'b0;
        @(negedge clk); #1;
        check_reset_vals("reset");

        // Zero-fill: one write per cycle, x1..x31 in order, pipeline frozen.
        reset_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            #1;
            check($sformatf("clr%0d wr", i), 32'(regs_rd_write_out), 32'd1);
            check($sformatf("clr%0d rd", i), 32'(regs_rd_out), 32'(i));
            check($sformatf("clr%0d val", i), regs_rd_value_out, 32'd0);
            check($sformatf("clr%0d stall", i), 32'(pipe_stall_out), 32'd1);
            check($sformatf("clr%0d rdy", i), 32'(dbg_ready_out), 32'd0);
            @(negedge clk);
        end
        #1 check("run pipe_stall", 32'(pipe_stall_out), 32'd0);
        pipe_read(5'd5, 32'd0, "x5 after clear");
        pipe_read(5'd31, 32'd0, "x31 after clear");

        for (int v = 0; v < 10; v++) begin
            stall_in = vecs[v].stall; rs1_in = vecs[v].rs1; rs2_in = vecs[v].rs2;
            wb_rd_in = vecs[v].wb_rd; wb_rd_write_in = vecs[v].wb_wr;
            wb_rd_value_in = vecs[v].wb_val; wb_flush_in = vecs[v].wb_flush;
            dbg_valid_in = vecs[v].dv; dbg_write_in = vecs[v].dw;
            dbg_addr_in = vecs[v].da; dbg_wdata_in = vecs[v].dd;
            #1;
            check($sformatf("v%0d regs_stall", v), 32'(regs_stall_out), 32'(vecs[v].e_rstall));
            check($sformatf("v%0d rs1", v), 32'(regs_rs1_out), 32'(vecs[v].e_rs1));
            check($sformatf("v%0d rs2", v), 32'(regs_rs2_out), 32'(vecs[v].e_rs2));
            check($sformatf("v%0d wr", v), 32'(regs_rd_write_out), 32'(vecs[v].e_wr));
            check($sformatf("v%0d rd", v), 32'(regs_rd_out), 32'(vecs[v].e_rd));
            check($sformatf("v%0d val", v), regs_rd_value_out, vecs[v].e_val);
            check($sformatf("v%0d rdy", v), 32'(dbg_ready_out), 32'(vecs[v].e_rdy));
            check($sformatf("v%0d pipe_stall", v), 32'(pipe_stall_out), 32'd0);
            @(negedge clk);
        end
        pipe_read(5'd7, 32'hDEADBEEF, "x7 after dbg write");
        pipe_read(5'd8, 32'h0000CAFE, "x8 after blocked dbg write");
        pipe_read(5'd6, 32'h00000011, "x6 wb write");

        // Starvation: writeback every cycle, held while pipe_stall_out is high.
        k = 0;
        for (int c = 1; c <= 6; c++) begin
            idle_inputs();
            wb_rd_in = 5'd12; wb_rd_write_in = 1'b1; wb_rd_value_in = 32'h100 + k;
            dbg_valid_in = (c <= 5); dbg_write_in = 1'b1; dbg_addr_in = 5'd3; dbg_wdata_in = 32'h1234;
            #1;
            if (c <= 4) begin
                check($sformatf("starve c%0d rdy", c), 32'(dbg_ready_out), 32'd0);
                check($sformatf("starve c%0d stall", c), 32'(pipe_stall_out), 32'd0);
                check($sformatf("starve c%0d rd", c), 32'(regs_rd_out), 32'd12);
            end else if (c == 5) begin
                check("starve c5 rdy", 32'(dbg_ready_out), 32'd1);
                check("starve c5 stall", 32'(pipe_stall_out), 32'd1);
                check("starve c5 rd", 32'(regs_rd_out), 32'd3);
                check("starve c5 val", regs_rd_value_out, 32'h1234);
            end else begin
                check("starve c6 stall", 32'(pipe_stall_out), 32'd0);
                check("starve c6 rd", 32'(regs_rd_out), 32'd12);
                check("starve c6 val", regs_rd_value_out, 32'h104);
            end
            if (!pipe_stall_out) k++;
            @(negedge clk);
        end
        pipe_read(5'd3, 32'h1234, "x3 after starve");
        pipe_read(5'd12, 32'h104, "x12 held wb");

        // Debug read borrowing rs1, pipeline addresses restored afterwards.
        dbg_wr(5'd4, 32'h55, "pre x4");
        dbg_wr(5'd9, 32'h99, "pre x9");
        dbg_wr(5'd10, 32'hAA, "pre x10");
        rs1_in = 5'd9; rs2_in = 5'd10;
        dbg_valid_in = 1'b1; dbg_write_in = 1'b0; dbg_addr_in = 5'd4;
        wb_rd_in = 5'd13; wb_rd_write_in = 1'b1; wb_rd_value_in = 32'h13;
        #1 check("rd T rdy", 32'(dbg_ready_out), 32'd1);
        check("rd T wb proceeds", 32'(regs_rd_out), 32'd13);
        @(negedge clk);
        idle_inputs();
        rs1_in = 5'd20; rs2_in = 5'd21;
        #1 check("rd T1 pipe_stall", 32'(pipe_stall_out), 32'd1);
        check("rd T1 regs_stall", 32'(regs_stall_out), 32'd0);
        check("rd T1 regs_rs1", 32'(regs_rs1_out), 32'd4);
        check("rd T1 rvalid", 32'(dbg_rvalid_out), 32'd0);
        @(negedge clk); #1;
        check("rd T2 rvalid", 32'(dbg_rvalid_out), 32'd1);
        check("rd T2 rdata", dbg_rdata_out, 32'h55);
        check("rd T2 regs_rs1", 32'(regs_rs1_out), 32'd9);
        check("rd T2 regs_rs2", 32'(regs_rs2_out), 32'd10);
        check("rd T2 pipe_stall", 32'(pipe_stall_out), 32'd1);
        @(negedge clk);
        rs1_in = 5'd9; rs2_in = 5'd10;
        #1 check("rd T3 pipe_stall", 32'(pipe_stall_out), 32'd0);
        check("rd T3 rs1 value", regs_rs1_value_in, 32'h99);
        check("rd T3 rs2 value", rf_rs2_val, 32'hAA);
        check("rd T3 rvalid", 32'(dbg_rvalid_out), 32'd0);
        check("rd T3 rdata hold", dbg_rdata_out, 32'h55);
        @(negedge clk);
        pipe_read(5'd13, 32'h13, "x13 wb in read accept");

        dbg_rd(5'd0, 32'd0, "rd x0");
        dbg_wr(5'd0, 32'hBAD, "wr x0");
        dbg_rd(5'd0, 32'd0, "rd x0 after wr");
        dbg_rd(5'd4, 32'h55, "rd x4 again");

        // Reset while in RD_ADDR aborts the read.
        dbg_valid_in = 1'b1; dbg_write_in = 1'b0; dbg_addr_in = 5'd9;
        @(negedge clk);
        idle_inputs();
        #1 check("abort in RD_ADDR", 32'(regs_rs1_out), 32'd9);
        reset_n = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("post abort c%0d rvalid", c), 32'(dbg_rvalid_out), 32'd0);
            check($sformatf("post abort c%0d rd", c), 32'(regs_rd_out), 32'(c + 1));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
